oled_power_seq: RTL and testbench

- Power-up/power-down sequencer for the SSD1306-class OLED panel on the 100 MHz clock domain.
- Drives the panel supply enables and reset line, and issues a fixed init command list to the SPI byte transmitter over a valid/ready handshake.
- Inserts the required millisecond delays using an internal tick/millisecond counter pair.
- Sits between top-level control (start) and the SPI transmitter and panel pins.

---
 rtl/oled_power_seq.sv | 237 +++++++++++++++++++++++
 tb/tb_oled_power_seq.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_power_seq.sv
// oled_power_seq: SSD1306-class OLED power-up sequencer (supplies, reset, init bytes)
// Ports: clk, rst (async high), start, cmd_data/cmd_valid/cmd_ready (SPI byte
//   handshake), dc, vdd_n, vbat_n, res_n, busy, init_done.
//   Optional `OLED_SHUTDOWN_EN adds input shutdown (power-down from DONE).
module oled_power_seq #(
    parameter int CLKS_PER_MS    = 100000,
    parameter int VDD_SETTLE_MS  = 1,
    parameter int RST_PULSE_MS   = 2,
    parameter int VBAT_SETTLE_MS = 100
) (
    input  logic       clk,
    input  logic       rst,
`ifdef OLED_SHUTDOWN_EN
    input  logic       shutdown,
`endif
    input  logic       start,
    output logic [7:0] cmd_data,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic       dc,
    output logic       vdd_n,
    output logic       vbat_n,
    output logic       res_n,
    output logic       busy,
    output logic       init_done
);

    localparam int M1     = (VDD_SETTLE_MS > RST_PULSE_MS) ?
                            VDD_SETTLE_MS : RST_PULSE_MS;
    localparam int MAX_MS = (M1 > VBAT_SETTLE_MS) ? M1 : VBAT_SETTLE_MS;
    localparam int MS_W   = $clog2(MAX_MS + 1);
    localparam int TICK_W = $clog2(CLKS_PER_MS);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_MS - 1);
    localparam logic [MS_W-1:0]   VDD_LAST  = MS_W'(VDD_SETTLE_MS - 1);
    localparam logic [MS_W-1:0]   RST_LAST  = MS_W'(RST_PULSE_MS - 1);
    localparam logic [MS_W-1:0]   VBAT_LAST = MS_W'(VBAT_SETTLE_MS - 1);

    // Last ROM index of each command segment
    localparam logic [2:0] SEG0_LAST = 3'd0;
    localparam logic [2:0] SEG1_LAST = 3'd4;
    localparam logic [2:0] SEG2_LAST = 3'd5;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WAIT_VDD,
        S_SEND,
        S_RES_LOW,
        S_RES_HIGH,
        S_VBAT_ON,
        S_DONE,
        S_SD_SEND,
        S_SD_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic [7:0]        cmd_data_q, cmd_data_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic              vdd_n_q, vdd_n_d;
    logic              vbat_n_q, vbat_n_d;
    logic              res_n_q, res_n_d;
    logic              busy_q, busy_d;
    logic              init_done_q, init_done_d;
    logic [TICK_W-1:0] tick_q;
    logic [MS_W-1:0]   ms_q;
    logic [MS_W-1:0]   wait_last;
    logic              in_wait;
    logic              tick_wrap;
    logic              wait_done;
    logic              xfer;

    function automatic logic [7:0] rom(input logic [2:0] i);
        case (i)
            3'd0:    return 8'hAE;
            3'd1:    return 8'h8D;
            3'd2:    return 8'h14;
            3'd3:    return 8'hD9;
            3'd4:    return 8'hF1;
            3'd5:    return 8'hAF;
            default: return 8'h00;
        endcase
    endfunction

    assign xfer      = cmd_valid_q && cmd_ready;
    assign tick_wrap = (tick_q == TICK_LAST);
    assign wait_done = tick_wrap && (ms_q == wait_last);

    always_comb begin
        wait_last = '0;
        in_wait   = 1'b1;
        case (state_q)
            S_WAIT_VDD:           wait_last = VDD_LAST;
            S_RES_LOW, S_RES_HIGH: wait_last = RST_LAST;
            S_VBAT_ON, S_SD_WAIT: wait_last = VBAT_LAST;
            default:              in_wait   = 1'b0;
        endcase
    end

    // Delay counters restart from zero on every state change so each wait
    // spans exactly N*CLKS_PER_MS cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q <= '0;
            ms_q   <= '0;
        end else if (state_d != state_q || !in_wait) begin
            tick_q <= '0;
            ms_q   <= '0;
        end else if (tick_wrap) begin
            tick_q <= '0;
            ms_q   <= ms_q + 1'b1;
        end else begin
            tick_q <= tick_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            cmd_data_q  <= 8'h00;
            cmd_valid_q <= 1'b0;
            vdd_n_q     <= 1'b1;
            vbat_n_q    <= 1'b1;
            res_n_q     <= 1'b1;
            busy_q      <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cmd_data_q  <= cmd_data_d;
            cmd_valid_q <= cmd_valid_d;
            vdd_n_q     <= vdd_n_d;
            vbat_n_q    <= vbat_n_d;
            res_n_q     <= res_n_d;
            busy_q      <= busy_d;
            init_done_q <= init_done_d;
        end
    end

    // Outputs are computed one cycle ahead so that every pin changes on the
    // same edge as the state it belongs to.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cmd_data_d  = cmd_data_q;
        cmd_valid_d = cmd_valid_q;
        vdd_n_d     = vdd_n_q;
        vbat_n_d    = vbat_n_q;
        res_n_d     = res_n_q;
        busy_d      = busy_q;
        init_done_d = init_done_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WAIT_VDD;
                    vdd_n_d = 1'b0;
                    busy_d  = 1'b1;
                    idx_d   = '0;
                end
            end
            S_WAIT_VDD, S_RES_HIGH, S_VBAT_ON: begin
                if (wait_done) begin
                    state_d     = S_SEND;
                    cmd_valid_d = 1'b1;
                    cmd_data_d  = rom(idx_q);
                end
            end
            S_RES_LOW: begin
                if (wait_done) begin
                    state_d = S_RES_HIGH;
                    res_n_d = 1'b1;
                end
            end
            S_SEND: begin
                if (xfer) begin
                    idx_d = idx_q + 3'd1;
                    unique case (1'b1)
                        (idx_q == SEG0_LAST): begin
                            state_d     = S_RES_LOW;
                            res_n_d     = 1'b0;
                            cmd_valid_d = 1'b0;
                        end
                        (idx_q == SEG1_LAST): begin
                            state_d     = S_VBAT_ON;
                            vbat_n_d    = 1'b0;
                            cmd_valid_d = 1'b0;
                        end
                        (idx_q == SEG2_LAST): begin
                            state_d     = S_DONE;
                            cmd_valid_d = 1'b0;
                            busy_d      = 1'b0;
                            init_done_d = 1'b1;
                        end
                        default: cmd_data_d = rom(idx_d);
                    endcase
                end
            end
            S_DONE: begin
`ifdef OLED_SHUTDOWN_EN
                if (shutdown) begin
                    state_d     = S_SD_SEND;
                    init_done_d = 1'b0;
                    busy_d      = 1'b1;
                    cmd_valid_d = 1'b1;
                    cmd_data_d  = 8'hAE;
                end
`endif
            end
            S_SD_SEND: begin
                if (xfer) begin
                    state_d     = S_SD_WAIT;
                    cmd_valid_d = 1'b0;
                    vbat_n_d    = 1'b1;
                end
            end
            S_SD_WAIT: begin
                if (wait_done) begin
                    state_d = S_IDLE;
                    vdd_n_d = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cmd_data  = cmd_data_q;
    assign cmd_valid = cmd_valid_q;
    assign dc        = 1'b0;
    assign vdd_n     = vdd_n_q;
    assign vbat_n    = vbat_n_q;
    assign res_n     = res_n_q;
    assign busy      = busy_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_oled_power_seq.sv
// tb_oled_power_seq: scoreboard bench for oled_power_seq
// Expected bytes are queued at stimulus time; a monitor pops them on transfers.
module tb_oled_power_seq;

    localparam int C       = 10;
    localparam int VDD_MS  = 1;
    localparam int RST_MS  = 2;
    localparam int VBAT_MS = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       cmd_ready = 1'b0;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       dc;
    logic       vdd_n;
    logic       vbat_n;
    logic       res_n;
    logic       busy;
    logic       init_done;
`ifdef OLED_SHUTDOWN_EN
    logic       shutdown = 1'b0;
`endif

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int bp_cnt = 0;
    bit rand_mode = 1'b0;
    bit b2b_mode  = 1'b0;
    bit sd_mode   = 1'b0;

    logic [7:0] exp_q[$];
    logic [7:0] init_list [6] = '{8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1, 8'hAF};

    oled_power_seq #(
        .CLKS_PER_MS   (C),
        .VDD_SETTLE_MS (VDD_MS),
        .RST_PULSE_MS  (RST_MS),
        .VBAT_SETTLE_MS(VBAT_MS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef OLED_SHUTDOWN_EN
        .shutdown (shutdown),
`endif
        .start    (start),
        .cmd_data (cmd_data),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .dc       (dc),
        .vdd_n    (vdd_n),
        .vbat_n   (vbat_n),
        .res_n    (res_n),
        .busy     (busy),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Ready driver: changes just after the rising edge, stable at negedge.
    initial forever begin
        @(posedge clk);
        #1;
        if (bp_cnt > 0) begin
            cmd_ready = 1'b0;
            bp_cnt--;
        end else if (rand_mode) begin
            cmd_ready = ($urandom_range(0, 2) != 0);
        end else begin
            cmd_ready = 1'b1;
        end
    end

    // Monitor: scoreboard pops plus interval checks between pin events.
    logic [7:0] p_data;
    logic p_vdd, p_vbat, p_res, p_valid, p_ready;
    int t_vdd, t_resl, t_resh, t_vbat, t_vboff, t_last_x;

    always @(negedge clk) begin
        if (rst) begin
            p_vdd = 1'b1; p_vbat = 1'b1; p_res = 1'b1;
            p_valid = 1'b0; p_ready = 1'b0; p_data = 8'h00;
        end else begin
            if (p_valid && !p_ready) begin
                chk("hold_valid", cmd_valid, 1);
                chk("hold_data", cmd_data, p_data);
            end
            if (!p_valid && cmd_valid) begin
                if (cmd_data == 8'hAE && !sd_mode)
                    chk("vdd_to_AE", cyc - t_vdd, VDD_MS * C);
                else if (cmd_data == 8'h8D)
                    chk("resh_to_8D", cyc - t_resh, RST_MS * C);
                else if (cmd_data == 8'hAF)
                    chk("vbat_to_AF", cyc - t_vbat, VBAT_MS * C);
            end
            if (cmd_valid && cmd_ready) begin
                chk("dc", dc, 0);
                if (b2b_mode && (cmd_data == 8'h14 || cmd_data == 8'hD9 ||
                                 cmd_data == 8'hF1))
                    chk("b2b", cyc - t_last_x, 1);
                t_last_x = cyc;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_byte: got %0h expected none", cmd_data);
                end else begin
                    chk("byte", cmd_data, exp_q.pop_front());
                end
            end
            if (p_vdd && !vdd_n) t_vdd = cyc;
            if (!p_vdd && vdd_n) begin
                chk("vbatoff_to_vddoff", cyc - t_vboff, VBAT_MS * C);
                chk("idle_busy", busy, 0);
            end
            if (p_res && !res_n) t_resl = cyc;
            if (!p_res && res_n) begin
                chk("res_low_len", cyc - t_resl, RST_MS * C);
                t_resh = cyc;
            end
            if (p_vbat && !vbat_n) t_vbat = cyc;
            if (!p_vbat && vbat_n) t_vboff = cyc;
            p_vdd = vdd_n; p_vbat = vbat_n; p_res = res_n;
            p_valid = cmd_valid; p_ready = cmd_ready; p_data = cmd_data;
        end
    end

    function automatic logic sig(input int w);
        case (w)
            0:       return init_done;
            1:       return vbat_n;
            2:       return cmd_valid && (cmd_data == 8'h8D);
            default: return vdd_n;
        endcase
    endfunction

    task automatic wait_sig(input int w, input logic val, input int maxc,
                            input string nm);
        int n = 0;
        while (sig(w) !== val && n < maxc) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (sig(w) !== val) begin
            fails++;
            $display("FAIL timeout_%s: got no event expected within %0d cycles",
                     nm, maxc);
        end
    endtask

    task automatic issue_start(input bit push);
        @(negedge clk);
        start = 1'b1;
        if (push) foreach (init_list[i]) exp_q.push_back(init_list[i]);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "_vdd_n"}, vdd_n, 1);
        chk({pfx, "_vbat_n"}, vbat_n, 1);
        chk({pfx, "_res_n"}, res_n, 1);
        chk({pfx, "_valid"}, cmd_valid, 0);
        chk({pfx, "_data"}, cmd_data, 0);
        chk({pfx, "_dc"}, dc, 0);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_done"}, init_done, 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        exp_q.delete();
        #1 chk_reset("async");
        @(negedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic chk_done(input string pfx);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_vdd_on"}, vdd_n, 0);
        chk({pfx, "_vbat_on"}, vbat_n, 0);
        chk({pfx, "_res_rel"}, res_n, 1);
        chk({pfx, "_valid0"}, cmd_valid, 0);
        chk({pfx, "_q_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset("por");
        #2 rst = 1'b0;

        // Full sequence, ready held high, stray start in WAIT_VDD.
        b2b_mode = 1'b1;
        issue_start(1'b1);
        repeat (2) @(negedge clk);
        chk("wvdd_busy", busy, 1);
        issue_start(1'b0);
        wait_sig(0, 1'b1, 500, "doneA");
        chk_done("A");
        b2b_mode = 1'b0;

        // Start in DONE is ignored.
        issue_start(1'b0);
        repeat (40) @(negedge clk);
        chk("ign_done", init_done, 1);
        chk_done("A2");

        // Reset while waiting on VBAT, then replay.
        pulse_reset();
        issue_start(1'b1);
        wait_sig(1, 1'b0, 500, "vbat_low");
        repeat (5) @(negedge clk);
        chk("wvbat_busy", busy, 1);
        chk("wvbat_done", init_done, 0);
        pulse_reset();

        // Backpressure on byte 8'h14.
        issue_start(1'b1);
        wait_sig(2, 1'b1, 500, "see_8D");
        bp_cnt = 7;
        repeat (4) @(negedge clk);
        chk("bp_valid", cmd_valid, 1);
        chk("bp_data", cmd_data, 8'h14);
        wait_sig(0, 1'b1, 500, "doneC");
        chk_done("C");

        // Random backpressure runs.
        rand_mode = 1'b1;
        for (int r = 0; r < 3; r++) begin
            pulse_reset();
            issue_start(1'b1);
            wait_sig(0, 1'b1, 2000, "doneR");
            chk_done("R");
        end

`ifdef OLED_SHUTDOWN_EN
        @(negedge clk);
        shutdown = 1'b1;
        sd_mode = 1'b1;
        exp_q.push_back(8'hAE);
        @(negedge clk);
        shutdown = 1'b0;
        chk("sd_done0", init_done, 0);
        chk("sd_busy1", busy, 1);
        wait_sig(3, 1'b1, 2000, "sd_vdd_off");
        chk("sd_vbat_off", vbat_n, 1);
        chk("sd_q_empty", exp_q.size(), 0);
        sd_mode = 1'b0;
        issue_start(1'b1);
        shutdown = 1'b1;
        @(negedge clk);
        shutdown = 1'b0;
        wait_sig(0, 1'b1, 2000, "doneS");
        chk_done("S");
`endif

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
